// File: rtl/sprite_attr_pkg.sv
// Shared sprite attribute RAM defaults and clear sequencer state type.
// Imported by the sprite attribute RAM top and its storage array.
package sprite_attr_pkg;

  localparam int SPR_ATTR_DEPTH = 256;
  localparam int SPR_ATTR_W     = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/sprite_attr_ram_mem.sv
// Plain byte-enable RAM array: one write port, one registered read port.
// No reset so that it maps onto block RAM.
module sprite_attr_mem
  import sprite_attr_pkg::*;
#(
  parameter int DATA_W = SPR_ATTR_W,
  parameter int DEPTH  = SPR_ATTR_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] ben_i,
  input  logic [ADDR_W-1:0]   waddr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic                re_i,
  input  logic [ADDR_W-1:0]   raddr_i,
  output logic [DATA_W-1:0]   rdata_o
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (ben_i[b]) begin
          mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Read-first: a same-cycle write is merged by the top.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_o <= mem[raddr_i];
    end
  end

endmodule

// File: rtl/sprite_attr_ram.sv
// Sprite attribute RAM: host byte-enable write, renderer read,
// write-first forwarding and a hardware clear sweep.
module sprite_attr_ram
  import sprite_attr_pkg::*;
#(
  parameter int DATA_W = SPR_ATTR_W,
  parameter int DEPTH  = SPR_ATTR_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                clr_req_i,
  output logic                busy_o,
  input  logic                wr_en_i,
  output logic                wr_ready_o,
  input  logic [DATA_W/8-1:0] ben_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic                rd_en_i,
  input  logic [ADDR_W-1:0]   rd_addr_i,
  output logic [DATA_W-1:0]   rd_data_o,
  output logic                rd_valid_o
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic              wr_acc;
  logic              mem_we;
  logic [NB-1:0]     mem_ben;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              valid_q;
  logic              zero_q;
  logic              fwd_q;
  logic [NB-1:0]     ben_q;
  logic [DATA_W-1:0] wdat_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        if (clr_req_i) begin
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clr_req_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy_o     = (state_q == ST_CLEAR);
    wr_ready_o = !busy_o;
  end

  // The sweep owns the write port while busy; host writes are dropped.
  assign wr_acc    = wr_en_i && wr_ready_o;
  assign mem_we    = busy_o || wr_acc;
  assign mem_addr  = busy_o ? cnt_q : wr_addr_i;
  assign mem_wdata = busy_o ? '0 : wr_data_i;
  assign mem_ben   = busy_o ? '1 : ben_i;

  sprite_attr_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .ben_i   (mem_ben),
    .waddr_i (mem_addr),
    .wdata_i (mem_wdata),
    .re_i    (rd_en_i),
    .raddr_i (rd_addr_i),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      zero_q  <= 1'b1;
      fwd_q   <= 1'b0;
      ben_q   <= '0;
      wdat_q  <= '0;
    end else begin
      valid_q <= rd_en_i;
      if (rd_en_i) begin
        zero_q <= busy_o;
        fwd_q  <= wr_acc && (wr_addr_i == rd_addr_i);
        ben_q  <= ben_i;
        wdat_q <= wr_data_i;
      end
    end
  end

  // Reads during a sweep see the already-cleared array.
  always_comb begin
    rd_data_o = mem_rdata;
    for (int b = 0; b < NB; b++) begin
      if (fwd_q && ben_q[b]) begin
        rd_data_o[8*b +: 8] = wdat_q[8*b +: 8];
      end
    end
    if (zero_q) begin
      rd_data_o = '0;
    end
  end

  assign rd_valid_o = valid_q;

endmodule
